// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state type and
// sizing constants used by the arbiter top and its round-robin picker.
package fifo_arb_pkg;

   // Arbiter FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Largest requester count the arbiter is sized for
   localparam int NUM_REQ_MAX = 8;

   // Default cap on words written under a single grant
   localparam int MAX_BURST_DEFAULT = 8;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request found searching
// upward from (last_ptr + 1) mod NUM_REQ. Purely combinational.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_vec,
   input  logic [$clog2(NUM_REQ)-1:0] last_ptr,
   output logic [$clog2(NUM_REQ)-1:0] pick_idx,
   output logic                       pick_valid
);

   localparam int IDX_W = $clog2(NUM_REQ);

   int               cand_s;
   logic [IDX_W-1:0] cand_idx_s;

   // Scan from the farthest candidate down to last_ptr+1 so the nearest hit is written last and wins
   always_comb begin
      pick_idx   = '0;
      pick_valid = 1'b0;
      cand_s     = 0;
      cand_idx_s = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand_s     = (int'(last_ptr) + k) % NUM_REQ;
         cand_idx_s = IDX_W'(cand_s);
         pick_idx   = req_vec[cand_idx_s] ? cand_idx_s : pick_idx;
         pick_valid = pick_valid | req_vec[cand_idx_s];
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Two-state FSM (IDLE/GRANT) with a registered one-hot grant; the write
// strobe, ack and data mux are combinational from the grant and live inputs.
// Build option: FIFO_ARB_PACKET_LOCK_EN -- when defined, a grant is held until
// the requester's word marked Last_in (capped at MAX_BURST words); when not
// defined, every grant covers exactly one word (word-level round robin).
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = MAX_BURST_DEFAULT
) (
   input  logic                          Clk,
   input  logic                          Clear_in,
   input  logic [NUM_REQ-1:0]            Req_in,
   input  logic [NUM_REQ-1:0]            Last_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
   output logic [NUM_REQ-1:0]            Grant_out,
   output logic [NUM_REQ-1:0]            Ack_out,
   input  logic                          Fifo_Full_in,
   output logic                          Fifo_WriteEn_out,
   output logic [DATA_WIDTH-1:0]         Fifo_Data_out
);

   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam logic [IDX_W-1:0]   LAST_RESET = IDX_W'(NUM_REQ - 1);
   localparam logic [BURST_W-1:0] BURST_CAP  = BURST_W'(MAX_BURST);

   arb_state_e          state_r, state_nxt_s;
   logic [NUM_REQ-1:0]  grant_r, grant_nxt_s;
   logic [IDX_W-1:0]    gidx_r, gidx_nxt_s;
   logic [IDX_W-1:0]    last_r, last_nxt_s;
   logic [BURST_W-1:0]  burst_r, burst_nxt_s;

   logic [IDX_W-1:0]    pick_idx_s;
   logic                pick_valid_s;
   logic                req_g_s;
   logic                last_g_s;
   logic                xfer_s;
   logic                rel_rule_s;
   logic                cap_hit_s;
   logic [BURST_W-1:0]  burst_inc_s;
   logic [DATA_WIDTH-1:0] data_s;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_vec    (Req_in),
      .last_ptr   (last_r),
      .pick_idx   (pick_idx_s),
      .pick_valid (pick_valid_s)
   );

   // Granted requester's request/last flags and the data mux (grant is one-hot or zero)
   always_comb begin
      req_g_s  = |(grant_r & Req_in);
      last_g_s = |(grant_r & Last_in);
      xfer_s   = req_g_s & ~Fifo_Full_in & ~Clear_in;
      data_s   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         data_s = data_s | (Data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_r[i]}});
      end
   end

`ifdef FIFO_ARB_PACKET_LOCK_EN
   // Packet mode: hold the grant until the word flagged as last is written
   assign rel_rule_s = last_g_s;
`else
   // Word mode: release after every write; Last_in is irrelevant (the OR only keeps it connected)
   assign rel_rule_s = 1'b1 | last_g_s;
`endif

   assign burst_inc_s      = burst_r + BURST_W'(1);
   assign cap_hit_s        = (burst_inc_s == BURST_CAP);
   assign Fifo_WriteEn_out = xfer_s;
   assign Fifo_Data_out    = data_s;
   assign Ack_out          = grant_r & {NUM_REQ{xfer_s}};
   assign Grant_out        = grant_r;

   // Next-state logic: arbitrate in IDLE, hold or release the grant in GRANT
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      gidx_nxt_s  = gidx_r;
      last_nxt_s  = last_r;
      burst_nxt_s = burst_r;
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s = GRANT;
               grant_nxt_s = NUM_REQ'(1) << pick_idx_s;
               gidx_nxt_s  = pick_idx_s;
               burst_nxt_s = '0;
            end else begin
               grant_nxt_s = '0;
               burst_nxt_s = '0;
            end
         end
         GRANT: begin
            if (!req_g_s || (xfer_s && (rel_rule_s || cap_hit_s))) begin
               // Always drop to IDLE so a new grant is preceded by a bubble
               state_nxt_s = IDLE;
               grant_nxt_s = '0;
               last_nxt_s  = gidx_r;
               burst_nxt_s = '0;
            end else if (xfer_s) begin
               burst_nxt_s = burst_inc_s;
            end else begin
               burst_nxt_s = burst_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            grant_nxt_s = '0;
            burst_nxt_s = '0;
         end
      endcase
   end

   // State registers with synchronous clear; clear aborts any grant in progress
   always_ff @(posedge Clk) begin
      if (Clear_in) begin
         state_r <= IDLE;
         grant_r <= '0;
         gidx_r  <= '0;
         last_r  <= LAST_RESET;
         burst_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         grant_r <= grant_nxt_s;
         gidx_r  <= gidx_nxt_s;
         last_r  <= last_nxt_s;
         burst_r <= burst_nxt_s;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=8).
// Stimulus pushes each expected FIFO write into a queue; a negedge monitor pops
// and compares whenever the DUT strobes Fifo_WriteEn_out.
// Packet-lock scenarios run only when FIFO_ARB_PACKET_LOCK_EN is defined.
module tb_fifo_write_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;

   logic          Clk = 1'b0;
   logic          Clear_in;
   logic [NR-1:0] Req_in;
   logic [NR-1:0] Last_in;
   logic [NR*DW-1:0] Data_in;
   logic [NR-1:0] Grant_out;
   logic [NR-1:0] Ack_out;
   logic          Fifo_Full_in;
   logic          Fifo_WriteEn_out;
   logic [DW-1:0] Fifo_Data_out;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  tests_run    = 0;
   int  tests_failed = 0;
   int  wr_cnt[NR];

   fifo_write_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (8)
   ) dut (
      .Clk              (Clk),
      .Clear_in         (Clear_in),
      .Req_in           (Req_in),
      .Last_in          (Last_in),
      .Data_in          (Data_in),
      .Grant_out        (Grant_out),
      .Ack_out          (Ack_out),
      .Fifo_Full_in     (Fifo_Full_in),
      .Fifo_WriteEn_out (Fifo_WriteEn_out),
      .Fifo_Data_out    (Fifo_Data_out)
   );

   always #5 Clk = ~Clk;

   // Fixed per-requester data: A0, B1, C2, D3
   function automatic logic [7:0] data_of(input int i);
      return 8'hA0 + 8'(i * 17);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push(input int idx);
      wr_t e;
      e.idx  = idx;
      e.data = data_of(idx);
      exp_q.push_back(e);
   endtask

   // Monitor: every write must match the scoreboard head; idle cycles must show no ack
   always @(negedge Clk) begin
      wr_t e;
      if (Fifo_WriteEn_out === 1'b1) begin
         check("no_write_while_full", 32'(Fifo_Full_in), 32'd0);
         check("no_write_while_clear", 32'(Clear_in), 32'd0);
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_write: ack 0x%0h data 0x%0h, no write expected", Ack_out, Fifo_Data_out);
         end else begin
            e = exp_q.pop_front();
            check("wr_data", 32'(Fifo_Data_out), 32'(e.data));
            check("wr_ack", 32'(Ack_out), 32'(1) << e.idx);
            wr_cnt[e.idx] = wr_cnt[e.idx] + 1;
         end
      end else begin
         check("ack_when_no_write", 32'(Ack_out), 32'd0);
      end
   end

   initial begin
      Clear_in     = 1'b1;
      Req_in       = '0;
      Last_in      = 4'b1111;
      Fifo_Full_in = 1'b0;
      Data_in      = {data_of(3), data_of(2), data_of(1), data_of(0)};
      for (int i = 0; i < NR; i++) wr_cnt[i] = 0;

      // Reset
      tick();
      tick();
      check("reset_grant", 32'(Grant_out), 32'd0);
      check("reset_we", 32'(Fifo_WriteEn_out), 32'd0);
      Clear_in = 1'b0;
      tick();
      check("idle_grant", 32'(Grant_out), 32'd0);
      check("idle_data_zero", 32'(Fifo_Data_out), 32'd0);

      // Req 1010 after reset: 1 wins first, bubble, then 3, alternating
      Req_in = 4'b1010;
      push(1); push(3); push(1); push(3);
      tick();
      check("rr_first_grant", 32'(Grant_out), 32'b0010);
      tick();
      check("rr_bubble", 32'(Grant_out), 32'd0);
      tick();
      check("rr_second_grant", 32'(Grant_out), 32'b1000);
      repeat (5) tick();
      Req_in = '0;
      tick();
      tick();
      check("t1_drained", 32'(exp_q.size()), 32'd0);

      // Full for 3 cycles while granted: grant held, nothing written
      Req_in       = 4'b0001;
      Fifo_Full_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("full_grant_held", 32'(Grant_out), 32'b0001);
         check("full_no_we", 32'(Fifo_WriteEn_out), 32'd0);
         check("full_no_ack", 32'(Ack_out), 32'd0);
      end
      tick();
      push(0);
      Fifo_Full_in = 1'b0;
      tick();
      check("full_release", 32'(Grant_out), 32'd0);
      Req_in = '0;

      // Clear mid-grant: no write, grant dropped, pointer reset so 0 beats 2
      Req_in       = 4'b0100;
      Fifo_Full_in = 1'b1;
      tick();
      check("clr_grant_before", 32'(Grant_out), 32'b0100);
      Clear_in     = 1'b1;
      Fifo_Full_in = 1'b0;
      Req_in       = 4'b0101;
      #1;
      check("clr_no_we", 32'(Fifo_WriteEn_out), 32'd0);
      check("clr_no_ack", 32'(Ack_out), 32'd0);
      tick();
      check("clr_grant_after", 32'(Grant_out), 32'd0);
      Clear_in = 1'b0;
      push(0);
      tick();
      check("clr_req0_wins", 32'(Grant_out), 32'b0001);
      tick();
      Req_in = '0;
      check("clr_release", 32'(Grant_out), 32'd0);
      tick();

      // All four request for 400 cycles: one write per two cycles, 50 each in order 1,2,3,0
      for (int i = 0; i < NR; i++) wr_cnt[i] = 0;
      for (int j = 0; j < 200; j++) push((j + 1) % NR);
      Req_in = 4'b1111;
      repeat (400) tick();
      Req_in = '0;
      tick();
      tick();
      for (int i = 0; i < NR; i++) check($sformatf("fair_cnt_%0d", i), 32'(wr_cnt[i]), 32'd50);
      check("fair_drained", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_ARB_PACKET_LOCK_EN
      // Packet of 5 from requester 2 stays contiguous, then bubble, then 0
      Last_in = 4'b0000;
      Req_in  = 4'b0101;
      repeat (5) push(2);
      tick();
      check("pkt_grant2", 32'(Grant_out), 32'b0100);
      repeat (4) tick();
      Last_in = 4'b0100;
      tick();
      Req_in  = 4'b0001;
      Last_in = 4'b0000;
      check("pkt_bubble", 32'(Grant_out), 32'd0);
      tick();
      check("pkt_grant0", 32'(Grant_out), 32'b0001);
      Req_in = '0;
      tick();
      tick();

      // Requester 1 never sends Last: capped at 8 words, then 0 gets the port
      Req_in = 4'b0011;
      repeat (8) push(1);
      tick();
      check("cap_grant1", 32'(Grant_out), 32'b0010);
      repeat (8) tick();
      check("cap_release", 32'(Grant_out), 32'd0);
      tick();
      check("cap_rearb0", 32'(Grant_out), 32'b0001);
      Req_in = '0;
      tick();
      tick();
      check("lock_drained", 32'(exp_q.size()), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
